// File: rtl/tt_capture_pkg.sv
// tt_capture_pkg: shared TX state type and UART frame geometry for tt_io_capture
package tt_capture_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int FRAME_BITS = 10;
  localparam int DATA_W = 8;
endpackage

// File: rtl/tt_capture_fifo.sv
// tt_capture_fifo: power-of-two FIFO whose full-state push is accepted only alongside a pop
module tt_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign data = mem[rd];
  always_ff @(posedge CLK)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + AW'(1);
      if (do_pop) rd <= rd + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/tt_io_capture.sv
// tt_io_capture: samples dut_out on dut_clk rising edges into a FIFO and streams it out as 8N1 UART; TT_CAPTURE_CHANGE_ONLY_EN pushes only changed values
module tt_io_capture
  import tt_capture_pkg::*;
#(
  parameter int BAUD_DIV = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              dut_clk,
  input  logic [DATA_W-1:0] dut_out,
  output logic              tx,
  output logic              overflow,
  output logic              busy
);
  localparam int LAST_BIT = FRAME_BITS - 3;
  logic dut_clk_q, cap, push, pop, full, empty, baud_end;
  logic [DATA_W-1:0] head, sh, sh_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  tx_state_t state, state_n;
  assign cap = dut_clk && !dut_clk_q;
`ifdef TT_CAPTURE_CHANGE_ONLY_EN
  logic [DATA_W-1:0] last;
  logic last_valid;
  assign push = cap && (!last_valid || dut_out != last);
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      last_valid <= 1'b0;
      last <= '0;
    end else if (push && (!full || pop)) begin
      last_valid <= 1'b1;
      last <= dut_out;
    end
  end
`else
  assign push = cap;
`endif
  tt_capture_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .CLK(CLK),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(dut_out),
    .data(head),
    .full(full),
    .empty(empty)
  );
  assign baud_end = cnt == 16'(BAUD_DIV - 1);
  assign busy = state != IDLE || !empty;
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      dut_clk_q <= 1'b0;
      overflow <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      dut_clk_q <= dut_clk;
      overflow <= overflow | (push & full & !pop);
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = (state == IDLE || baud_end) ? '0 : cnt + 16'd1;
    idx_n = idx;
    sh_n = sh;
    pop = 1'b0;
    tx = 1'b1;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        sh_n = head;
        state_n = START;
      end
      START: begin
        tx = 1'b0;
        if (baud_end) begin
          state_n = DATA;
          idx_n = '0;
        end
      end
      DATA: begin
        tx = sh[idx];
        if (baud_end) begin
          idx_n = idx + 3'd1;
          state_n = idx == 3'(LAST_BIT) ? STOP : DATA;
        end
      end
      STOP: state_n = baud_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tt_io_capture.sv
// tb_tt_io_capture: vector table, directed corner sequences and random traffic against a frame-level reference model
module tb_tt_io_capture;
  localparam int B = 4;
  localparam int D = 4;
  logic CLK = 1'b0, rst_n = 1'b0, dut_clk = 1'b0;
  logic [7:0] dut_out = '0;
  logic tx, overflow, busy;

  tt_io_capture #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .dut_clk(dut_clk),
    .dut_out(dut_out),
    .tx(tx),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0, cyc = 0;
  bit armed = 0;
  logic s_tx, s_busy, s_ovf;

  // reference model: queue of waiting bytes plus position within the current frame
  logic [7:0] m_q[$];
  bit m_act = 0, m_prev = 0, m_ovf = 0, m_lv = 0;
  int m_t = 0;
  logic [7:0] m_cur = '0, m_last = '0;

  // serial decoder watching tx
  bit mon_act = 0;
  int mon_t = 0;
  logic [7:0] mon_sh = '0;
  logic [7:0] mon_bytes[$];
  int mon_starts[$], mon_ends[$];
  logic [7:0] e_q[$];

  typedef struct {
    logic r, c;
    logic [7:0] d;
    logic etx, ebusy, eovf;
  } vec_t;
  vec_t tbl[44];

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic m_tx();
    if (!m_act) return 1'b1;
    if (m_t < B) return 1'b0;
    if (m_t < 9 * B) return m_cur[(m_t - B) / B];
    return 1'b1;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [7:0] d);
    bit pop, ok;
    if (!r) begin
      m_q.delete();
      m_act = 0; m_t = 0; m_prev = 0; m_ovf = 0; m_lv = 0;
      armed = 1;
      return;
    end
    pop = !m_act && m_q.size() != 0;
    ok = c && !m_prev;
`ifdef TT_CAPTURE_CHANGE_ONLY_EN
    ok = ok && (!m_lv || d != m_last);
`endif
    if (pop) begin
      m_cur = m_q.pop_front();
      m_act = 1;
      m_t = 0;
    end else if (m_act) begin
      m_t++;
      if (m_t == 10 * B) m_act = 0;
    end
    if (ok) begin
      if (m_q.size() < D) begin
        m_q.push_back(d);
        m_lv = 1;
        m_last = d;
      end else m_ovf = 1;
    end
    m_prev = c;
  endtask

  task automatic tick(input logic r, input logic c, input logic [7:0] d);
    rst_n = r; dut_clk = c; dut_out = d;
    model_step(r, c, d);
    @(negedge CLK);
    cyc++;
    s_tx = tx; s_busy = busy; s_ovf = overflow;
    if (armed) begin
      chk("tx", s_tx, m_tx());
      chk("busy", s_busy, m_act || m_q.size() != 0);
      chk("overflow", s_ovf, m_ovf);
      if (!r) mon_act = 0;
      else if (!mon_act) begin
        if (s_tx == 1'b0) begin
          mon_act = 1; mon_t = 0;
          mon_starts.push_back(cyc);
        end
      end else begin
        mon_t++;
        if (mon_t >= B && mon_t < 9 * B && mon_t % B == B / 2) mon_sh[(mon_t - B) / B] = s_tx;
        if (mon_t == 9 * B + B / 2) chk("stop_bit", s_tx, 1);
        if (mon_t == 10 * B - 1) begin
          mon_bytes.push_back(mon_sh);
          mon_ends.push_back(cyc);
          mon_act = 0;
        end
      end
    end
  endtask

  task automatic mon_clear();
    mon_bytes.delete(); mon_starts.delete(); mon_ends.delete();
  endtask

  task automatic chk_frames(input string n);
    chk({n, "_count"}, mon_bytes.size(), e_q.size());
    foreach (e_q[i]) if (i < mon_bytes.size()) chk($sformatf("%s_byte%0d", n, i), mon_bytes[i], e_q[i]);
  endtask

  initial begin
    logic [7:0] a5;
    logic rc;
    bit rr;
    a5 = 8'hA5;
    rc = 1'b0;
    @(negedge CLK);

    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, a5, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 10 * B; t++)
      tbl[2 + t] = '{1'b1, 1'b1, a5,
                     (t < B) ? 1'b0 : (t < 9 * B) ? a5[(t - B) / B] : 1'b1, 1'b1, 1'b0};
    tbl[42] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[43] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 44; i++) begin
      tick(tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d_tx", i), s_tx, tbl[i].etx);
      chk($sformatf("vec%0d_busy", i), s_busy, tbl[i].ebusy);
      chk($sformatf("vec%0d_ovf", i), s_ovf, tbl[i].eovf);
    end
    e_q = '{8'hA5};
    chk_frames("single");

    tick(1'b0, 1'b0, 8'h00);
    mon_clear();
    for (int v = 1; v <= 6; v++) begin
      tick(1'b1, 1'b1, 8'(v));
      tick(1'b1, 1'b0, 8'(v));
    end
    chk("ovf_set", s_ovf, 1);
    repeat (260) tick(1'b1, 1'b0, 8'h00);
    e_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    chk_frames("overflow");
    chk("ovf_held", s_ovf, 1);

    mon_clear();
    tick(1'b1, 1'b1, 8'hA5);
    repeat (18) tick(1'b1, 1'b0, 8'h00);
    chk("pre_reset_ovf", s_ovf, 1);
    chk("pre_reset_busy", s_busy, 1);
    tick(1'b0, 1'b0, 8'h00);
    chk("reset_tx", s_tx, 1);
    chk("reset_busy", s_busy, 0);
    chk("reset_ovf", s_ovf, 0);
    repeat (60) tick(1'b1, 1'b0, 8'h00);
    chk("reset_no_frame", mon_bytes.size(), 0);
    chk("reset_idle_tx", s_tx, 1);

    tick(1'b0, 1'b0, 8'h00);
    mon_clear();
    e_q = '{8'h3C, 8'h3C, 8'h3C, 8'h41};
    foreach (e_q[i]) begin
      tick(1'b1, 1'b1, e_q[i]);
      tick(1'b1, 1'b0, 8'h00);
    end
`ifdef TT_CAPTURE_CHANGE_ONLY_EN
    e_q = '{8'h3C, 8'h41};
`endif
    repeat (200) tick(1'b1, 1'b0, 8'h00);
    chk_frames("change_only");

    tick(1'b0, 1'b0, 8'h00);
    mon_clear();
    tick(1'b1, 1'b1, 8'hA5);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h3C);
    repeat (100) tick(1'b1, 1'b0, 8'h00);
    e_q = '{8'hA5, 8'h3C};
    chk_frames("b2b");
    if (mon_starts.size() == 2 && mon_ends.size() == 2) begin
      chk("b2b_start_gap", mon_starts[1] - mon_starts[0], 10 * B + 1);
      chk("b2b_total", mon_ends[1] - mon_starts[0] + 1, 20 * B + 1);
    end

    tick(1'b0, 1'b0, 8'h00);
    mon_clear();
    repeat (100) tick(1'b1, 1'b1, 8'h11);
    tick(1'b1, 1'b0, 8'h00);
    repeat (100) tick(1'b1, 1'b1, 8'h22);
    repeat (60) tick(1'b1, 1'b0, 8'h00);
    e_q = '{8'h11, 8'h22};
    chk_frames("edge_qual");

    for (int i = 0; i < 3000; i++) begin
      rr = $urandom_range(0, 399) != 0;
      if ($urandom_range(0, (i < 1500) ? 1 : 30) == 0) rc = ~rc;
      tick(rr, rc, 8'($urandom_range(0, (i % 2 == 1) ? 255 : 3)));
    end
    repeat (100) tick(1'b1, 1'b0, 8'h00);
    chk("final_idle_busy", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
